des_iter_core: RTL and testbench
================================

Name: des_iter_core

Overview:
- Parametrised single-DES engine that performs the 16 Feistel rounds in 16/ROUNDS_PER_CYCLE iterations over a shared round datapath.
- It adds ready/valid handshakes, per-block encrypt/decrypt selection and internal key-order reversal.
- It replaces the fixed sixteen-round wrapper as the building block instantiated three times by the 3DES top level.
- IP and FP are applied inside the block; round keys come from the external key schedule.

Parameters:
- ROUNDS_PER_CYCLE, 1, number of Feistel rounds combinationally chained per clock. Legal values are 1, 2, 4, 8 and 16; any other value fails at elaboration.
- ITERS, 16/ROUNDS_PER_CYCLE, derived and not overridable; number of RUN cycles per block.
- CNT_W, max(1, clog2(ITERS)), derived; width of the iteration counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- n_rst  in  1  synchronous active-low reset
- in_valid  in  1  input block and keys are valid
- in_ready  out  1  block can accept a new input block
- decrypt  in  1  0 = encrypt (keys k1..k16), 1 = decrypt (keys k16..k1); sampled on accept
- data_in  in  64  plaintext or ciphertext, DES bit 1 = bit 63
- round_keys  in  768  {k1,...,k16}, k1 in bits 767:720; sampled on accept
- out_valid  out  1  data_out holds a finished block
- out_ready  in  1  downstream accepts data_out
- data_out  out  64  result after FP, DES bit 1 = bit 63
- busy  out  1  high in RUN and DONE

Behaviour:
- Reset: when n_rst=0 at a clock edge the block goes to state IDLE.
  - Reset values: in_ready=1 (the first cycle after reset), out_valid=0, busy=0, data_out=0, counter=0.
  - Internal L/R, key and decrypt registers clear to 0.
- Reset asserted mid-RUN or mid-DONE discards the block; no output is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid and in_ready at an edge: {L,R} <= IP(data_in); latch round_keys and decrypt; cnt <= 0; next state RUN.
- RUN:
  - in_ready=0.
  - Each cycle applies ROUNDS_PER_CYCLE rounds in sequence. The j-th chained round (j=0..R-1) uses key index i = cnt*R + j.
  - Encrypt uses key k(i+1). Decrypt uses key k(16-i).
  - Each round computes L' = R and R' = L xor f(R, K), with f = E-expansion, key xor, S1..S8, P.
  - cnt increments each cycle.
  - When cnt = ITERS-1:
    - data_out <= FP({R16, L16}), i.e. the final swap is undone.
    - out_valid <= 1.
    - Next state DONE.
- DONE:
  - out_valid=1; data_out is held stable until out_ready=1 at an edge.
  - On that edge out_valid <= 0 and the state goes to IDLE.
  - in_ready=0 in DONE; there is no same-cycle turnaround.
- Latency:
  - out_valid rises ITERS cycles after the accept edge (1 cycle for R=16, 16 cycles for R=1).
  - Throughput is one block per ITERS+2 cycles with out_ready held high.
- in_valid while not ready: ignored. The source must hold the block until it is accepted.
- data_in, round_keys and decrypt may change freely after acceptance; the block uses only latched copies.
- out_ready while out_valid=0: no effect.
- data_out keeps its last value after the handshake until the next block completes.
- The S-boxes, E, P, IP and FP are pure functions inside this block; no RAMs are used.

Test Plan:
- All-zero key vector: round_keys=0, data_in=0000000000000000, encrypt -> data_out=8CA64DE9C1B123A7. Check out_valid exactly ITERS cycles after accept, for each legal R.
- Key 133457799BBCDFF1 (subkeys from the bench key-schedule model, k1=1B02EFFC7072), data_in=0123456789ABCDEF -> 85E813540F0AB405.
  - Feed that result back with decrypt=1 and the same round_keys -> 0123456789ABCDEF.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid.
  - out_valid and data_out stay stable throughout.
  - in_ready stays 0 throughout.
  - A new in_valid offered during the hold is not accepted.
  - Raising out_ready returns the block to IDLE the next cycle.
- Input isolation: change data_in, round_keys and decrypt to random values every cycle after the accept -> result still 85E813540F0AB405.
- Reset mid-RUN: drop n_rst for one cycle at cnt=ITERS/2 -> out_valid never asserts for that block, in_ready=1 the next cycle, and a subsequent all-zero vector yields 8CA64DE9C1B123A7.
- Back-to-back stream of 100 random blocks and keys with out_ready random:
  - Every output matches the reference model in order.
  - No block is lost or duplicated.
  - Handshake protocol assertions hold.

Source files
------------

// File: rtl/des_iter_core.sv
// Iterative single-DES engine: IP, 16 Feistel rounds folded over
// ROUNDS_PER_CYCLE chained round stages, FP; ready/valid on both sides.
module des_iter_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         decrypt,
    input  logic [63:0]  data_in,
    input  logic [767:0] round_keys,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  data_out,
    output logic         busy
);

    localparam int ITERS = 16 / ROUNDS_PER_CYCLE;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rounds
        $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
    };
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
    };
    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2, 8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
    };
    // One row per entry (box*4 + row), column 0 in the top nibble.
    localparam logic [63:0] SBOX [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic               accept, last;
    logic [63:0]        lr_q, lr_next;
    logic [767:0]       key_q;
    logic               dec_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        l_v, r_v, t_v;
    logic [47:0]        k_v;
    int unsigned        idx;

    // Table entries are DES bit numbers (bit 1 = MSB).
    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int unsigned k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - IP_T[6'(k)])];
        return y;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int unsigned k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - FP_T[6'(k)])];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] key);
        logic [47:0] e;
        logic [31:0] s, p;
        logic [63:0] srow;
        logic [5:0]  six;
        e = '0;
        s = '0;
        p = '0;
        for (int unsigned n = 0; n < 48; n++) e[6'(47 - n)] = r[5'(32 - E_T[6'(n)])];
        e = e ^ key;
        for (int unsigned b = 0; b < 8; b++) begin
            six  = e[6'(47 - 6 * b) -: 6];
            srow = SBOX[5'(4 * b + {six[5], six[0]})];
            s[5'(31 - 4 * b) -: 4] = srow[6'(63 - 4 * six[4:1]) -: 4];
        end
        for (int unsigned n = 0; n < 32; n++) p[5'(31 - n)] = s[5'(32 - P_T[5'(n)])];
        return p;
    endfunction

    // Chain of ROUNDS_PER_CYCLE rounds; decrypt walks the latched key vector from the far end.
    always_comb begin
        l_v = lr_q[63:32];
        r_v = lr_q[31:0];
        t_v = '0;
        k_v = '0;
        idx = 0;
        for (int unsigned j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            idx = 32'(cnt_q) * 32'(ROUNDS_PER_CYCLE) + j;
            k_v = dec_q ? key_q[10'(48 * idx) +: 48] : key_q[10'(720 - 48 * idx) +: 48];
            t_v = l_v ^ feistel(r_v, k_v);
            l_v = r_v;
            r_v = t_v;
        end
        lr_next = {l_v, r_v};
    end

    // Next-state logic and handshake decode.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                accept  = 1'b1;
                state_d = RUN;
            end
            RUN: if (cnt_q == CNT_W'(ITERS - 1)) begin
                last    = 1'b1;
                state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Block capture, round iteration and result register.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            lr_q     <= '0;
            key_q    <= '0;
            dec_q    <= 1'b0;
            cnt_q    <= '0;
            data_out <= '0;
        end else if (accept) begin
            lr_q  <= ip(data_in);
            key_q <= round_keys;
            dec_q <= decrypt;
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            lr_q  <= lr_next;
            cnt_q <= last ? '0 : cnt_q + 1'b1;
            if (last) data_out <= fp({lr_next[31:0], lr_next[63:32]});
        end
    end

endmodule

// File: tb/tb_des_iter_core.sv
// Scoreboard bench for des_iter_core: directed known-answer vectors,
// back-pressure, input isolation, mid-run reset and a random stream.
module tb_des_iter_core;

    localparam logic [63:0] ZERO_CT = 64'h8CA64DE9C1B123A7;
    localparam logic [63:0] PT1     = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT1     = 64'h85E813540F0AB405;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };
    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1
    };
    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
    };
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int SB [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}
    };

    logic         clk = 1'b0;
    logic         n_rst, in_valid, decrypt;
    logic         ready_ctl, rand_mode, rnd_bit;
    logic         out_ready, in_ready, out_valid, busy;
    logic [63:0]  data_in, data_out;
    logic [767:0] round_keys;
    logic         alt_in_ready [4];
    logic         alt_out_valid [4];
    logic         alt_busy [4];
    logic [63:0]  alt_data_out [4];

    logic [63:0]  exp_q [$];
    int           n_cmp = 0, n_fail = 0, n_pushed = 0, n_popped = 0;
    logic         prev_ov = 1'b0, prev_or = 1'b0, prev_rst = 1'b0;
    logic [63:0]  prev_do = '0;

    always #5 clk = ~clk;

    assign out_ready = rand_mode ? rnd_bit : ready_ctl;
    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    des_iter_core #(.ROUNDS_PER_CYCLE(1)) dut (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
        .decrypt(decrypt), .data_in(data_in), .round_keys(round_keys),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .busy(busy)
    );

    for (genvar g = 0; g < 4; g++) begin : g_alt
        des_iter_core #(.ROUNDS_PER_CYCLE(2 << g)) u_alt (
            .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(alt_in_ready[g]),
            .decrypt(decrypt), .data_in(data_in), .round_keys(round_keys),
            .out_valid(alt_out_valid[g]), .out_ready(out_ready),
            .data_out(alt_data_out[g]), .busy(alt_busy[g])
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [767:0] key_sched(input logic [63:0] key);
        logic [55:0]  cd;
        logic [27:0]  c, d;
        logic [47:0]  k;
        logic [767:0] ks;
        ks = '0;
        for (int n = 0; n < 56; n++) cd[55 - n] = key[64 - PC1[n]];
        c = cd[55:28];
        d = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < SHIFTS[i]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int n = 0; n < 48; n++) k[47 - n] = cd[56 - PC2[n]];
            ks[767 - 48 * i -: 48] = k;
        end
        return ks;
    endfunction

    // Reference DES; the final permutation is taken as the inverse of IP.
    function automatic logic [63:0] des_model(input logic [63:0] din, input logic [767:0] ks, input bit dec);
        logic [63:0] t, pre, res;
        logic [31:0] l, r, s, f, nr;
        logic [47:0] e;
        logic [5:0]  six;
        int          ki;
        for (int n = 0; n < 64; n++) t[63 - n] = din[64 - IP_T[n]];
        l = t[63:32];
        r = t[31:0];
        for (int rnd = 0; rnd < 16; rnd++) begin
            ki = dec ? 15 - rnd : rnd;
            for (int n = 0; n < 48; n++) e[47 - n] = r[32 - E_T[n]];
            e = e ^ ks[767 - 48 * ki -: 48];
            for (int b = 0; b < 8; b++) begin
                six = e[47 - 6 * b -: 6];
                s[31 - 4 * b -: 4] = 4'(SB[b][{six[5], six[0]} * 16 + six[4:1]]);
            end
            for (int n = 0; n < 32; n++) f[31 - n] = s[32 - P_T[n]];
            nr = l ^ f;
            l = r;
            r = nr;
        end
        pre = {r, l};
        for (int n = 0; n < 64; n++) res[64 - IP_T[n]] = pre[63 - n];
        return res;
    endfunction

    function automatic logic [767:0] rand_keys();
        logic [767:0] v;
        for (int i = 0; i < 24; i++) v[32 * i +: 32] = $urandom();
        return v;
    endfunction

    // Output monitor: pops the scoreboard on every handshake and checks hold stability.
    always @(negedge clk) begin
        if (n_rst && prev_rst && prev_ov && !prev_or) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", data_out, prev_do);
        end
        if (n_rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got %h, expected no output", data_out);
            end else begin
                n_popped++;
                check("data_out", data_out, exp_q.pop_front());
            end
        end
        prev_ov  <= out_valid;
        prev_or  <= out_ready;
        prev_rst <= n_rst;
        prev_do  <= data_out;
    end

    task automatic send(input logic [63:0] d, input logic [767:0] k, input logic dec,
                        input logic [63:0] exp, input bit track);
        bit ok = 1'b0;
        data_in    = d;
        round_keys = k;
        decrypt    = dec;
        in_valid   = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1 within 200 cycles");
            in_valid = 1'b0;
            return;
        end
        if (track) begin
            exp_q.push_back(exp);
            n_pushed++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [767:0] ks1, rk;
        logic [63:0]  d, alt_res [4];
        int           lat [5];
        bit           ok;
        logic         dec;

        n_rst = 1'b0; in_valid = 1'b0; decrypt = 1'b0; data_in = '0; round_keys = '0;
        ready_ctl = 1'b1; rand_mode = 1'b0;
        ks1 = key_sched(64'h133457799BBCDFF1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data_out", data_out, 64'd0);
        n_rst = 1'b1;

        // All-zero vector on every legal R, with latency measured from the accept edge.
        lat = '{default: 0};
        send('0, '0, 1'b0, ZERO_CT, 1'b1);
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk);
            #1;
            if (out_valid && lat[0] == 0) lat[0] = c;
            for (int g = 0; g < 4; g++)
                if (alt_out_valid[g] && lat[g + 1] == 0) begin
                    lat[g + 1] = c;
                    alt_res[g] = alt_data_out[g];
                end
        end
        check("latency_r1", 64'(lat[0]), 64'd16);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("latency_r%0d", 2 << g), 64'(lat[g + 1]), 64'(16 / (2 << g)));
            check($sformatf("zero_ct_r%0d", 2 << g), alt_res[g], ZERO_CT);
        end
        wait_drain(50);

        // Known answer, then decrypt of its result.
        send(PT1, ks1, 1'b0, CT1, 1'b1);
        wait_drain(50);
        send(CT1, ks1, 1'b1, PT1, 1'b1);
        wait_drain(50);

        // Back-pressure with a competing input offered during the hold.
        ready_ctl = 1'b0;
        send(PT1, ks1, 1'b0, CT1, 1'b1);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("bp_valid_seen", 64'(ok), 64'd1);
        data_in = '0; round_keys = '0; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_data", data_out, CT1);
        end
        in_valid = 1'b0;
        ready_ctl = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_ready", 64'(in_ready), 64'd1);
        check("bp_idle_busy", 64'(busy), 64'd0);
        check("bp_data_kept", data_out, CT1);
        repeat (20) @(posedge clk);
        #1;
        check("bp_no_accept", 64'(busy), 64'd0);
        exp_q.delete();

        // Input isolation: inputs scrambled every cycle after accept.
        send(PT1, ks1, 1'b0, CT1, 1'b1);
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            data_in = {$urandom(), $urandom()};
            round_keys = rand_keys();
            decrypt = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        wait_drain(50);

        // Reset at cnt = ITERS/2 discards the block.
        send(PT1, ks1, 1'b0, CT1, 1'b0);
        repeat (8) @(posedge clk);
        #1 n_rst = 1'b0;
        @(posedge clk);
        #1 n_rst = 1'b1;
        check("mr_in_ready", 64'(in_ready), 64'd1);
        check("mr_out_valid", 64'(out_valid), 64'd0);
        check("mr_data_out", data_out, 64'd0);
        repeat (20) @(posedge clk);
        #1;
        check("mr_no_output", 64'(out_valid), 64'd0);
        send('0, '0, 1'b0, ZERO_CT, 1'b1);
        wait_drain(50);

        // Random back-to-back stream with random back-pressure.
        rand_mode = 1'b1;
        for (int i = 0; i < 100; i++) begin
            d   = {$urandom(), $urandom()};
            rk  = rand_keys();
            dec = 1'($urandom_range(0, 1));
            send(d, rk, dec, des_model(d, rk, dec), 1'b1);
        end
        wait_drain(3000);
        rand_mode = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("block_count", 64'(n_popped), 64'(n_pushed));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
